conv2d_stream: RTL
==================

# conv2d_stream

Streaming, parametrised 2-D convolution engine. It replaces the fixed 5×5, 6-channel MAC, which needs a bench to present all 25 window taps at once. This block accepts a raster-order pixel stream, builds K×K windows internally with line buffers, and computes all OUT_CH output channels per window position. Outputs come out on a valid/ready stream. It sits between the input image source and the pooling/activation stage of the conv layer.

## Interface
- IMG_W, 32: input image width (pixels).
- IMG_H, 32: input image height.
- K, 5: square kernel size, ≥2.
- OUT_CH, 6: output channel count.
- DATA_W, 16: signed pixel/weight/bias width.
- ACC_W, 40: signed accumulator/output width. Must be ≥ 2·DATA_W + clog2(K·K+1).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame, honoured only in IDLE.
- w_valid  in  1  weight/bias word valid; always accepted in LOAD.
- w_data  in  DATA_W  weight/bias word, signed.
- pix_valid  in  1  pixel valid.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- pix_data  in  DATA_W  pixel, signed, raster order.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  convolution result, signed.
- out_ch  out  clog2(OUT_CH)  channel of out_data.
- out_row, out_col  out  clog2(IMG_H), clog2(IMG_W)  output position.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
- OUT_H = IMG_H−K+1 and OUT_W = IMG_W−K+1. Stride is 1 and there is no padding.
- FSM states: IDLE, LOAD, STREAM, COMPUTE, EMIT, DONE.
- **IDLE → LOAD** on start.
- **LOAD** consumes K·K·OUT_CH weights, channel-major with row-major taps (word 25·n+12 is the centre tap of channel n for K=5). It then consumes OUT_CH biases. After the last word it goes to STREAM.
- **STREAM**: pix_ready=1.
  - Each accepted pixel shifts into the line buffer/window.
  - When the accepted pixel is at row ≥ K−1 and col ≥ K−1, the window is complete. The FSM clears the channel counter and goes to COMPUTE. Otherwise it stays in STREAM with no output.
- **COMPUTE** (one cycle, pix_ready=0):
  - out_data ← Σ window[i]·w[ch][i] + sext(bias[ch]), all K·K products in parallel.
  - out_ch, out_row, out_col are registered. Then → EMIT.
- **EMIT**: out_valid=1, and all out_* signals are held stable until out_ready.
  - On handshake, if ch < OUT_CH−1: ch++ and → COMPUTE.
  - Else, if the position was (OUT_H−1, OUT_W−1): → DONE.
  - Else: → STREAM.
- **DONE**: done=1 for one cycle, then → IDLE.
- Output order: position-major (raster), channels 0..OUT_CH−1 within each position.
- Arithmetic: signed two's complement and full-precision products. There is no saturation or rounding, and bias is added unshifted.
- start in any state other than IDLE is ignored. w_valid outside LOAD is ignored.
- Weights persist in IDLE, but every frame reloads them (LOAD is mandatory).

## Timing
- Reset values: pix_ready=0, out_valid=0, out_data=0, out_ch=0, out_row=0, out_col=0, busy=0, done=0. FSM=IDLE and the weight/bias bank is cleared to 0.
- Line-buffer RAM is not reset. Stale contents never reach out_data because windows are only formed after K−1 full rows.
- start sampled at edge E → LOAD in cycle E+1, and the first weight is accepted at edge E+1.
- Window-completing pixel accepted at edge E0: COMPUTE in cycle E0+1, first out_valid in cycle E0+2, pix_ready=0 from cycle E0+1.
- Each channel costs 2 cycles minimum (COMPUTE+EMIT). A window costs 2·OUT_CH cycles with out_ready held high.
- pix_ready returns high in the cycle after the last channel handshake.
- done asserts in the cycle after the final handshake. busy drops the cycle after done.
- If rst_n is asserted mid-frame, all outputs go to reset values immediately and any partial frame is discarded.

## Structure
- conv_pkg: FSM state enum, and width helpers (PIX_IDX_W, CH_W, ROW_W, COL_W) derived from the parameters.
- Sub-module conv_line_buffer: K−1 row delay lines of IMG_W×DATA_W plus a K×K window register. It outputs the flattened window and row/col counters.
- The top level holds the weight bank, MAC/adder tree, FSM and output registers.

## Test plan
- **Uniform ones**: all pixels=1, all weights=1, biases=0 → 28·28·6=4704 results all equal 25, order (0,0,ch0..5),(0,1,…), done pulses once.
- **Ramp centre tap**: pixel=row·32+col, channel-0 centre tap=1, other weights=0, bias0=0 → ch0 at (r,c) = (r+2)·32+(c+2), e.g. (0,0)=66 and (27,27)=957.
- **Sign/bias**: pixels=3, weights=−1, biases=5 → every result = −70.
- **Extremes**: pixels=−32768, weights=−32768, biases=32767 → 26843578367, with no wrap at ACC_W=40.
- **Backpressure**: out_ready low for 10 cycles mid-window, then random 50% → out_* stable while stalled, no loss or reorder, pix_ready=0 throughout.
- **Reset and parameter variant**: rst_n low after 100 pixels → reset values and IDLE, then a reloaded frame is correct. Separately, with K=3, IMG 6×6, OUT_CH=2 → 32 results matching the golden model.

Source files
------------

// File: rtl/conv2d_stream_pkg.sv
// Shared types and width helpers for the streaming 2-D convolution engine.
package conv2d_stream_pkg;

    // Frame-level control states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_COMPUTE,
        S_EMIT,
        S_DONE
    } state_t;

    // Index width for a count of n items; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pix_idx_width(input int img_w, input int img_h);
        return idx_w(img_w * img_h);
    endfunction

    function automatic int ch_width(input int out_ch);
        return idx_w(out_ch);
    endfunction

    function automatic int row_width(input int img_h);
        return idx_w(img_h);
    endfunction

    function automatic int col_width(input int img_w);
        return idx_w(img_w);
    endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Control, weight, pixel and result streams of conv2d_stream.
interface conv2d_stream_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CH_W   = 3,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 5
);
    logic              start;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [CH_W-1:0]   out_ch;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              busy;
    logic              done;

    // Engine side.
    modport slave (
        input  start, w_valid, w_data, pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_data, out_ch, out_row, out_col, busy, done
    );

    // Source / sink side.
    modport master (
        output start, w_valid, w_data, pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_data, out_ch, out_row, out_col, busy, done
    );
endinterface

// File: rtl/conv2d_stream_line_buffer.sv
// K-1 row delay lines plus a KxK sliding window over a raster pixel stream.
// o_row/o_col give the raster position of the next pixel to be pushed.
module conv2d_stream_line_buffer
    import conv2d_stream_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int DATA_W = 16,
    parameter int ROW_W  = row_width(IMG_H),
    parameter int COL_W  = col_width(IMG_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic [DATA_W-1:0]       i_pix,
    output logic [K*K*DATA_W-1:0]   o_win,
    output logic [ROW_W-1:0]        o_row,
    output logic [COL_W-1:0]        o_col
);
    // r_lines[j][c] holds pixel (row - (K-1-j), c); row K-1 of the window is the live pixel.
    logic [DATA_W-1:0] r_lines [K-1][IMG_W];
    logic [DATA_W-1:0] r_win   [K][K];
    logic [DATA_W-1:0] w_col   [K];
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;

    // Vertical column entering the window on this push.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        for (int j = 0; j < K; j++) w_col[j] = '0;
        for (int j = 0; j < K - 1; j++) w_col[j] = r_lines[j][r_col];
        w_col[K-1] = i_pix;
    end

    // Shift the delay lines up one row at this column and slide the window left.
    // NOTE: line RAM and window carry no reset; stale data is flushed before the first full window.
    always_ff @(posedge clk) begin
        if (i_push) begin
            for (int j = 0; j < K - 1; j++) r_lines[j][r_col] <= w_col[j+1];
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) r_win[i][j] <= r_win[i][j+1];
                r_win[i][K-1] <= w_col[i];
            end
        end
    end

    // Raster position counters, wrapping at the end of the frame.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_push) begin
            if (r_col == COL_W'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Flatten the window row-major: tap i*K+j is window row i, column j.
    always_comb begin
        o_win = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                o_win[(i*K+j)*DATA_W +: DATA_W] = r_win[i][j];
    end

    assign o_row = r_row;
    assign o_col = r_col;
endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution: weight load, windowing, per-channel MAC and result stream.
module conv2d_stream
    import conv2d_stream_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int OUT_CH = 6,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    conv2d_stream_if.slave  bus
);
    localparam int KK      = K * K;
    localparam int OUT_H   = IMG_H - K + 1;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int NWEIGHT = OUT_CH * KK;
    localparam int NWORD   = NWEIGHT + OUT_CH;
    localparam int LD_W    = idx_w(NWORD);
    localparam int CH_W    = ch_width(OUT_CH);
    localparam int ROW_W   = row_width(IMG_H);
    localparam int COL_W   = col_width(IMG_W);

    state_t                    r_state, w_next;
    logic [LD_W-1:0]           r_ld_cnt;
    logic [CH_W-1:0]           r_ch;
    logic [ROW_W-1:0]          r_pos_row;
    logic [COL_W-1:0]          r_pos_col;
    logic signed [DATA_W-1:0]  r_wgt  [NWEIGHT];
    logic signed [DATA_W-1:0]  r_bias [OUT_CH];
    logic signed [ACC_W-1:0]   r_out_data;
    logic [CH_W-1:0]           r_out_ch;
    logic [ROW_W-1:0]          r_out_row;
    logic [COL_W-1:0]          r_out_col;

    logic [KK*DATA_W-1:0]      w_win;
    logic [ROW_W-1:0]          w_row;
    logic [COL_W-1:0]          w_col;
    logic signed [DATA_W-1:0]  w_sel_wgt [KK];
    logic signed [DATA_W-1:0]  w_sel_bias;
    logic signed [2*DATA_W-1:0] w_prod [KK];
    logic signed [ACC_W-1:0]   w_sum;
    logic w_pix_acc, w_win_full, w_last_word, w_last_ch, w_last_pos, w_frame_start;
    logic w_pix_ready, w_out_valid, w_busy, w_done;

    assign w_frame_start = (r_state == S_IDLE) && bus.start;
    assign w_pix_acc     = (r_state == S_STREAM) && bus.pix_valid;
    assign w_win_full    = (int'(w_row) >= K - 1) && (int'(w_col) >= K - 1);
    assign w_last_word   = (r_ld_cnt == LD_W'(NWORD - 1));
    assign w_last_ch     = (r_ch == CH_W'(OUT_CH - 1));
    assign w_last_pos    = (r_pos_row == ROW_W'(OUT_H - 1)) && (r_pos_col == COL_W'(OUT_W - 1));

    conv2d_stream_line_buffer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_frame_start),
        .i_push  (w_pix_acc),
        .i_pix   (bus.pix_data),
        .o_win   (w_win),
        .o_row   (w_row),
        .o_col   (w_col)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_LOAD;
            S_LOAD:    if (bus.w_valid && w_last_word) w_next = S_STREAM;
            S_STREAM:  if (w_pix_acc && w_win_full) w_next = S_COMPUTE;
            S_COMPUTE: w_next = S_EMIT;
            S_EMIT: begin
                if (bus.out_ready) begin
                    if (!w_last_ch)      w_next = S_COMPUTE;
                    else if (w_last_pos) w_next = S_DONE;
                    else                 w_next = S_STREAM;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        w_pix_ready = (r_state == S_STREAM);
        w_out_valid = (r_state == S_EMIT);
        w_busy      = (r_state != S_IDLE);
        w_done      = (r_state == S_DONE);
    end

    // Weight/bias bank: channel-major weights then biases, loaded word by word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt <= '0;
            for (int i = 0; i < NWEIGHT; i++) r_wgt[i] <= '0;
            for (int n = 0; n < OUT_CH; n++) r_bias[n] <= '0;
        end else if (w_frame_start) begin
            r_ld_cnt <= '0;
        end else if (r_state == S_LOAD && bus.w_valid) begin
            for (int i = 0; i < NWEIGHT; i++)
                if (r_ld_cnt == LD_W'(i)) r_wgt[i] <= $signed(bus.w_data);
            for (int n = 0; n < OUT_CH; n++)
                if (r_ld_cnt == LD_W'(NWEIGHT + n)) r_bias[n] <= $signed(bus.w_data);
            r_ld_cnt <= r_ld_cnt + LD_W'(1);
        end
    end

    // Select the current channel's kernel and bias.
    always_comb begin
        w_sel_bias = '0;
        for (int i = 0; i < KK; i++) w_sel_wgt[i] = '0;
        for (int n = 0; n < OUT_CH; n++) begin
            if (r_ch == CH_W'(n)) begin
                w_sel_bias = r_bias[n];
                for (int i = 0; i < KK; i++) w_sel_wgt[i] = r_wgt[n*KK + i];
            end
        end
    end

    // Full-precision products summed with the sign-extended bias.
    always_comb begin
        w_sum = ACC_W'(w_sel_bias);
        for (int i = 0; i < KK; i++) begin
            w_prod[i] = (2*DATA_W)'($signed(w_win[i*DATA_W +: DATA_W])) * (2*DATA_W)'(w_sel_wgt[i]);
            w_sum     = w_sum + ACC_W'(w_prod[i]);
        end
    end

    // Window position, channel counter and registered result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch       <= '0;
            r_pos_row  <= '0;
            r_pos_col  <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
        end else begin
            case (r_state)
                S_STREAM: begin
                    if (w_pix_acc && w_win_full) begin
                        r_ch      <= '0;
                        r_pos_row <= w_row - ROW_W'(K - 1);
                        r_pos_col <= w_col - COL_W'(K - 1);
                    end
                end
                S_COMPUTE: begin
                    r_out_data <= w_sum;
                    r_out_ch   <= r_ch;
                    r_out_row  <= r_pos_row;
                    r_out_col  <= r_pos_col;
                end
                S_EMIT: if (bus.out_ready && !w_last_ch) r_ch <= r_ch + CH_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.pix_ready = w_pix_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_row   = r_out_row;
    assign bus.out_col   = r_out_col;
endmodule
